// File: rtl/seq_divider_module.sv
`default_nettype none
// ============================================================================
// Module     : seq_divider_module
// Description: Sequential radix-2 restoring divider. One trial subtraction
//              (a + ~b + 1) per cycle, WIDTH iterations per division, then
//              quotient/remainder with divide-by-zero and overflow flags.
//              Build option: define DIV_SIGNED_EN for two's-complement
//              (truncating) division; undefined gives unsigned-only with v
//              tied low.
// Ports      : clk       - clock, rising edge
//              rst       - asynchronous active-high reset
//              start     - request, accepted when busy=0
//              dividend  - numerator   [WIDTH-1:0], sampled on acceptance
//              divisor   - denominator [WIDTH-1:0], sampled on acceptance
//              busy      - high while iterating
//              done      - one-cycle pulse, results valid
//              quotient  - result [WIDTH-1:0], held
//              remainder - result [WIDTH-1:0], held
//              dz        - divide-by-zero flag, held
//              v         - signed overflow flag, held
// Revision   : 1.0 - initial release
// ============================================================================
module seq_divider_module #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             v
);
    localparam int               c_cnt_w   = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_den;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dz;
    logic               r_done;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept   = start && (r_state != c_run);
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == c_cnt_one);

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value is below 2*divisor and the WIDTH+1 bit trial
    // difference never wraps: its top bit is a reliable sign.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift + ~{1'b0, r_den} + (WIDTH+1)'(1);
    assign w_ge       = ~w_trial[WIDTH];
    assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

`ifdef DIV_SIGNED_EN
    logic r_q_neg;
    logic r_r_neg;
    logic r_v;

    // Magnitudes are held as unsigned WIDTH-bit values, so |most negative|
    // (2^(WIDTH-1)) is representable without a wider iteration path.
    assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + c_one) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor  + c_one) : divisor;
    assign w_quo_fix = r_q_neg ? (~w_quo_next + c_one) : w_quo_next;
    assign w_rem_fix = r_r_neg ? (~w_rem_next + c_one) : w_rem_next;
    assign v         = r_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            r_v <= 1'b0;
            if (!w_div_zero) begin
                r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_r_neg <= dividend[WIDTH-1];
            end
        end else if ((r_state == c_run) && w_last) begin
            // A positive quotient with the MSB set only arises from
            // most-negative / -1; the negation wraps back to most-negative.
            r_v <= !r_q_neg && w_quo_next[WIDTH-1];
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_quo_fix = w_quo_next;
    assign w_rem_fix = w_rem_next;
    assign v         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (start) begin
                    w_next = w_div_zero ? c_done : c_run;
                end else begin
                    w_next = c_idle;
                end
            end
            c_run:   w_next = w_last ? c_done : c_run;
            default: w_next = c_idle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (r_state == c_run);
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_den       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is the registered image of the DONE state, so the pulse
            // follows the cycle in which results are committed.
            r_done <= (r_state == c_done);
            if (w_accept) begin
                if (w_div_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend;
                    r_dz        <= 1'b1;
                end else begin
                    r_rem <= '0;
                    r_quo <= w_dvd_mag;
                    r_den <= w_dvs_mag;
                    r_cnt <= c_cnt_load;
                    r_dz  <= 1'b0;
                end
            end else if (r_state == c_run) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt - c_cnt_one;
                if (w_last) begin
                    r_quotient  <= w_quo_fix;
                    r_remainder <= w_rem_fix;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dz        = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_module.sv
`default_nettype none
// ============================================================================
// Module     : tb_seq_divider_module
// Description: Self-checking bench for seq_divider_module (WIDTH=4). A
//              cycle-level arithmetic model predicts every output each cycle;
//              directed vectors carry hand-computed literal results. Honours
//              DIV_SIGNED_EN when defined.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seq_divider_module;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;
    logic         v;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         v;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         v;
    } vec_t;

    seq_divider_module #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .v         (v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference arithmetic
    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t t;
        int   sa;
        int   sb;
        t = '0;
        if (b == '0) begin
            t.q  = '1;
            t.r  = a;
            t.dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -(1 << (W - 1)) && sb == -1) begin
                t.q = a;
                t.r = '0;
                t.v = 1'b1;
            end else begin
                t.q = W'(sa / sb);
                t.r = W'(sa % sb);
            end
`else
            sa = int'(a);
            sb = int'(b);
            t.q = W'(sa / sb);
            t.r = W'(sa % sb);
`endif
        end
        return t;
    endfunction

    // Cycle model: expectations for the current cycle, and edge numbers
    // of pending events.
    bit   m_busy;
    bit   m_done;
    res_t m_res;
    res_t m_pend;
    int   m_done_edge;
    int   m_commit;
    int   m_run_hi;

    initial begin
        int   e;
        bit   nd;
        res_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy      = 1'b0;
                m_done      = 1'b0;
                m_res       = '0;
                m_pend      = '0;
                m_done_edge = -1;
                m_commit    = -1;
                m_run_hi    = -1;
            end
            chk("busy",      int'(busy),      int'(m_busy));
            chk("done",      int'(done),      int'(m_done));
            chk("quotient",  int'(quotient),  int'(m_res.q));
            chk("remainder", int'(remainder), int'(m_res.r));
            chk("dz",        int'(dz),        int'(m_res.dz));
            chk("v",         int'(v),         int'(m_res.v));
            if (!rst) begin
                e  = cyc + 1;
                nd = (e == m_done_edge);
                if (start && !m_busy) begin
                    t = ref_div(dividend, divisor);
                    if (t.dz) begin
                        m_res       = t;
                        m_done_edge = e + 1;
                        m_commit    = -1;
                    end else begin
                        m_res.dz    = 1'b0;
                        m_res.v     = 1'b0;
                        m_pend      = t;
                        m_commit    = e + W;
                        m_done_edge = e + W + 1;
                        m_run_hi    = e + W - 1;
                    end
                end else if (e == m_commit) begin
                    m_res = m_pend;
                end
                m_busy = (e <= m_run_hi);
                m_done = nd;
            end
        end
    end

    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit immediate, output int acc);
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        acc      = cyc;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(output int dedge, output bit saw_busy);
        dedge    = -1;
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
            if (done) begin
                dedge = cyc;
                break;
            end
        end
        if (dedge < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout at cycle %0d: got no done, expected done within 40 cycles", cyc);
        end
    endtask

    task automatic run_one(input vec_t t, input bit immediate);
        int acc;
        int dedge;
        bit sb;
        pulse(t.a, t.b, immediate, acc);
        wait_done(dedge, sb);
        chk("latency",  dedge - acc, t.dz ? 1 : W + 1);
        chk("lit_q",    int'(quotient),  int'(t.q));
        chk("lit_r",    int'(remainder), int'(t.r));
        chk("lit_dz",   int'(dz),        int'(t.dz));
        chk("lit_v",    int'(v),         int'(t.v));
        if (t.dz) chk("dz_busy_seen", int'(sb), 0);
    endtask

    vec_t vecs [8];
    vec_t v_ign;
    vec_t v_rst;
    vec_t v_b2b1;
    vec_t v_b2b2;

    initial begin
        int acc;
        int dedge;
        bit sb;
`ifdef DIV_SIGNED_EN
        vecs[0] = {4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};  // -7 / 2
        vecs[1] = {4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1};  // -8 / -1 overflow
        vecs[2] = {4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0};  // -8 / 1
        vecs[3] = {4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0};  // 7 / -2
        vecs[4] = {4'h7, 4'h0, 4'hF, 4'h7, 1'b1, 1'b0};  // 7 / 0
        vecs[5] = {4'h5, 4'hD, 4'hF, 4'h2, 1'b0, 1'b0};  // 5 / -3
        vecs[6] = {4'hF, 4'h2, 4'h0, 4'hF, 1'b0, 1'b0};  // -1 / 2
        vecs[7] = {4'h9, 4'h9, 4'h1, 4'h0, 1'b0, 1'b0};  // -7 / -7
        v_ign   = {4'hF, 4'h4, 4'h0, 4'hF, 1'b0, 1'b0};  // -1 / 4
        v_rst   = {4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};  // -7 / 2
        v_b2b1  = {4'hD, 4'h3, 4'hF, 4'h0, 1'b0, 1'b0};  // -3 / 3
        v_b2b2  = {4'h6, 4'h2, 4'h3, 4'h0, 1'b0, 1'b0};
`else
        vecs[0] = {4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 1'b0};
        vecs[1] = {4'd7,  4'd0,  4'hF,  4'd7, 1'b1, 1'b0};
        vecs[2] = {4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 1'b0};
        vecs[3] = {4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 1'b0};
        vecs[4] = {4'd5,  4'd15, 4'd0,  4'd5, 1'b0, 1'b0};
        vecs[5] = {4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 1'b0};
        vecs[6] = {4'd8,  4'd3,  4'd2,  4'd2, 1'b0, 1'b0};
        vecs[7] = {4'd1,  4'd0,  4'hF,  4'd1, 1'b1, 1'b0};
        v_ign   = {4'd15, 4'd4,  4'd3,  4'd3, 1'b0, 1'b0};
        v_rst   = {4'd9,  4'd2,  4'd4,  4'd1, 1'b0, 1'b0};
        v_b2b1  = {4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 1'b0};
        v_b2b2  = {4'd6,  4'd2,  4'd3,  4'd0, 1'b0, 1'b0};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      int'(busy),      0);
        chk("rst_done",      int'(done),      0);
        chk("rst_quotient",  int'(quotient),  0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dz",        int'(dz),        0);
        chk("rst_v",         int'(v),         0);
        rst = 1'b0;

        foreach (vecs[i]) run_one(vecs[i], 1'b0);

        // Start re-pulsed while busy must be ignored
        pulse(v_ign.a, v_ign.b, 1'b0, acc);
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dedge, sb);
        chk("ign_latency", dedge - acc, W + 1);
        chk("ign_q", int'(quotient),  int'(v_ign.q));
        chk("ign_r", int'(remainder), int'(v_ign.r));

        // Reset mid-operation aborts immediately
        pulse(v_rst.a, v_rst.b, 1'b0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy),      0);
        chk("abort_done", int'(done),      0);
        chk("abort_q",    int'(quotient),  0);
        chk("abort_r",    int'(remainder), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_one(v_rst, 1'b0);

        // Back-to-back: second start issued in the done cycle
        run_one(v_b2b1, 1'b0);
        run_one(v_b2b2, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog at cycle %0d: got no summary, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
